rob_commit_writer: RTL
======================

# rob_commit_writer

In-order commit buffer that drives the write side of the architectural (logical) register file. Dispatch allocates entries tagged with a destination register, execution units complete entries out of order by tag, and the block retires them strictly in allocation order. Each retirement produces the `Reg_write` / `logical_address` / `write_data` triple consumed by the logical register file.

## Interface
- `DEPTH`, 8: number of buffer entries; must be a power of two.
- `TAG_W`, 3: tag width; equals log2(`DEPTH`).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alloc_valid`  in  1  dispatch requests a new entry.
- `alloc_rd`  in  5  destination logical register of the new entry.
- `alloc_ready`  out  1  entry available; combinational, equals `count < DEPTH`.
- `alloc_tag`  out  TAG_W  tag the next allocation receives (tail index).
- `cpl_valid`  in  1  completion strobe from execution.
- `cpl_tag`  in  TAG_W  entry being completed.
- `cpl_data`  in  32  result value.
- `flush`  in  1  discard all in-flight entries.
- `Reg_write`  out  1  registered commit strobe to the register file.
- `logical_address`  out  5  registered commit destination.
- `write_data`  out  32  registered commit value.
- `count`  out  TAG_W+1  number of valid entries.
- `empty`  out  1  `count == 0`.

## Operation
- Storage per entry: `valid`, `done`, `rd[4:0]`, `data[31:0]`. Head and tail pointers are TAG_W+1 bits wide, with the MSB used as the wrap bit. `count = tail - head`, modulo 2^(TAG_W+1).
- Allocate: when `alloc_valid && alloc_ready`, the entry at `tail` gets `valid=1`, `done=0`, `rd=alloc_rd`, and `tail` increments. When `alloc_valid` is high and `alloc_ready` is low, the request is ignored and no state changes.
- Complete: when `cpl_valid` is high and entry `cpl_tag` is valid, that entry gets `done=1` and `data=cpl_data`.
  - Completion to an invalid entry is ignored.
  - A repeated completion to a done entry overwrites `data`.
- Commit: at most one per cycle. It happens when the head entry has `valid && done`, both as registered state.
  - The head entry is cleared and `head` increments.
  - `logical_address <= rd` and `write_data <= data`.
  - `Reg_write <= (rd != 0)`. Entries targeting x0 retire silently.
- Cycles without a commit: `Reg_write <= 0`. `logical_address` and `write_data` hold their previous values.
- Flush has priority over allocate, complete and commit in the same cycle:
  - all `valid` and `done` bits clear;
  - `head = tail = 0`;
  - `Reg_write <= 0`.
- Simultaneous events:
  - Allocate and commit in the same cycle: both take effect, and `count` is unchanged.
  - When full, `alloc_ready` is 0 even if a commit occurs that cycle. There is no bypass.
  - Completion and allocation to the same tag in the same cycle: the completion is ignored, because the entry is not yet valid.
  - Completion to the head entry in the same cycle it is examined: it does not commit that cycle. It commits in the following cycle.
- Reset (asserted at any time, including mid-operation): all entries invalid, pointers 0, `Reg_write=0`, `logical_address=0`, `write_data=0`. Therefore `count=0`, `empty=1`, `alloc_ready=1`, `alloc_tag=0`.

## Timing
- Allocation accepted at the edge ending cycle N → entry valid from cycle N+1, and `count` reflects it in N+1.
- Completion accepted at the edge ending cycle M → `done` visible in M+1.
- Head `valid && done` in cycle K → `Reg_write` high during cycle K+1 for exactly one cycle. The register file captures at the end of K+1.
- Minimum dispatch-to-architectural-write: allocate in cycle N, complete in cycle N+1, `Reg_write` high in cycle N+3.
- Back-to-back: N consecutive done head entries produce N consecutive `Reg_write` cycles (when no entry targets x0).
- Wrap-around: after 2^(TAG_W+1) allocations, pointers return to 0. Full vs. empty is distinguished by the wrap bit.

## Test plan
- Reset then single op:
  - Stimulus: release `reset`; allocate `rd=5`; complete tag 0 with `0xDEADBEEF` the next cycle.
  - Required: `Reg_write=1`, `logical_address=5`, `write_data=0xDEADBEEF` two cycles after the completion; `empty=1` afterwards.
- Out-of-order completion:
  - Stimulus: allocate `rd=1,2,3` (tags 0,1,2); complete tags 2, 1, 0 on consecutive cycles with values 0x33, 0x22, 0x11.
  - Required: writes occur in order x1=0x11, x2=0x22, x3=0x33 on three consecutive cycles.
- Full/backpressure:
  - Stimulus: allocate 8 entries without completing; hold `alloc_valid` high.
  - Required: `count=8`, `alloc_ready=0`, and the 9th request is dropped. After tag 0 completes and commits, `alloc_ready=1` and `alloc_tag=0` (wrapped).
- x0 destination:
  - Stimulus: allocate `rd=0`, then `rd=7`; complete both.
  - Required: the first retirement keeps `Reg_write=0`; the next cycle writes x7. `count` reaches 0.
- Flush:
  - Stimulus: allocate 4 entries; complete 2 of them; assert `flush` in the same cycle tag 0 would commit.
  - Required: no `Reg_write`, `count=0`, `alloc_tag=0`. A late `cpl_valid` for tag 1 is ignored.
- Async reset mid-stream:
  - Stimulus: assert `reset` low between clock edges while `Reg_write=1`.
  - Required: `Reg_write`, `count`, `logical_address`, `write_data` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rob_commit_writer.sv
// In-order commit buffer: allocates tagged entries, accepts out-of-order completions,
// and retires entries in allocation order as registered register-file write strobes.
module rob_commit_writer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cpl_valid,
  input  logic [TAG_W-1:0] cpl_tag,
  input  logic [31:0]      cpl_data,
  input  logic             flush,
  output logic             Reg_write,
  output logic [4:0]       logical_address,
  output logic [31:0]      write_data,
  output logic [TAG_W:0]   count,
  output logic             empty
);

  logic             entry_valid [DEPTH];
  logic             entry_done  [DEPTH];
  logic [4:0]       entry_rd    [DEPTH];
  logic [31:0]      entry_data  [DEPTH];
  logic [TAG_W:0]   head;
  logic [TAG_W:0]   tail;
  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             do_alloc;
  logic             do_commit;

  // Pointers carry an extra wrap bit so full and empty differ when indices match.
  assign head_idx    = head[TAG_W-1:0];
  assign tail_idx    = tail[TAG_W-1:0];
  assign count       = tail - head;
  assign empty       = (count == '0);
  assign alloc_ready = (count < (TAG_W+1)'(DEPTH));
  assign alloc_tag   = tail_idx;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_commit   = entry_valid[head_idx] && entry_done[head_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head            <= '0;
      tail            <= '0;
      Reg_write       <= 1'b0;
      logical_address <= '0;
      write_data      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_valid[i] <= 1'b0;
        entry_done[i]  <= 1'b0;
        entry_rd[i]    <= '0;
        entry_data[i]  <= '0;
      end
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      Reg_write <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_valid[i] <= 1'b0;
        entry_done[i]  <= 1'b0;
      end
    end else begin
      Reg_write <= 1'b0;
      if (do_commit) begin
        Reg_write       <= (entry_rd[head_idx] != 5'd0);
        logical_address <= entry_rd[head_idx];
        write_data      <= entry_data[head_idx];
        head            <= head + 1'b1;
      end
      if (do_alloc) begin
        tail <= tail + 1'b1;
      end
      // Completion checks registered valid, so a same-cycle allocation of that tag wins.
      for (int i = 0; i < DEPTH; i++) begin
        if (do_commit && (head_idx == TAG_W'(i))) begin
          entry_valid[i] <= 1'b0;
          entry_done[i]  <= 1'b0;
        end else if (do_alloc && (tail_idx == TAG_W'(i))) begin
          entry_valid[i] <= 1'b1;
          entry_done[i]  <= 1'b0;
          entry_rd[i]    <= alloc_rd;
        end else if (cpl_valid && (cpl_tag == TAG_W'(i)) && entry_valid[i]) begin
          entry_done[i]  <= 1'b1;
          entry_data[i]  <= cpl_data;
        end
      end
    end
  end

endmodule
